// File: rtl/tawas_thread_sched.sv
// Barrel-thread scheduler: per-thread enable/stall state, a rotating issue slot, and decode/store stage tracking.
// Optional macro TAWAS_SKIP_IDLE_EN selects skip-idle issue instead of strict fixed rotation.
module tawas_thread_sched #(
    parameter int THREAD_W = 5,
    parameter logic [(1<<THREAD_W)-1:0] START_MASK = {{((1<<THREAD_W)-1){1'b0}}, 1'b1}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [(1<<THREAD_W)-1:0] thread_en_set,
    input  logic [(1<<THREAD_W)-1:0] thread_en_clr,
    input  logic [(1<<THREAD_W)-1:0] stall_set,
    input  logic [(1<<THREAD_W)-1:0] stall_clr,
    output logic                     thread_load_en,
    output logic [THREAD_W-1:0]      thread_load,
    output logic                     thread_decode_en,
    output logic [THREAD_W-1:0]      thread_decode,
    output logic                     thread_store_en,
    output logic [THREAD_W-1:0]      thread_store,
    output logic [(1<<THREAD_W)-1:0] thread_mask,
    output logic [(1<<THREAD_W)-1:0] thread_rdy,
    output logic                     idle
);
    localparam int N = 1 << THREAD_W;

    logic [N-1:0]        en_q;
    logic [N-1:0]        stall_q;
    logic [THREAD_W-1:0] ptr_q;
    logic                load_en_q, dec_en_q, st_en_q;
    logic [THREAD_W-1:0] load_q, dec_q, st_q;

    logic                sel_valid;
    logic [THREAD_W-1:0] sel_id;
    logic [THREAD_W-1:0] ptr_next;

    assign thread_mask = en_q;
    assign thread_rdy  = en_q & ~stall_q;
    assign idle        = ~|thread_rdy;

`ifdef TAWAS_SKIP_IDLE_EN
    logic [N-1:0]        eligible;
    logic [THREAD_W-1:0] cand;

    // Threads still in load or decode are excluded so one thread never
    // occupies two pipeline stages closer than three cycles apart.
    always_comb begin
        eligible  = thread_rdy;
        sel_valid = 1'b0;
        sel_id    = ptr_q;
        cand      = ptr_q;
        if (load_en_q) eligible[load_q] = 1'b0;
        if (dec_en_q)  eligible[dec_q]  = 1'b0;
        // Scan from the farthest offset down so the nearest eligible thread wins.
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr_q + THREAD_W'(i);
            if (eligible[cand]) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
        ptr_next = sel_valid ? sel_id + THREAD_W'(1) : ptr_q + THREAD_W'(1);
    end
`else
    assign sel_valid = thread_rdy[ptr_q];
    assign sel_id    = ptr_q;
    assign ptr_next  = ptr_q + THREAD_W'(1);
`endif

    // Stages shift every cycle with no backpressure; a stall only blocks future issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= START_MASK;
            stall_q   <= '0;
            ptr_q     <= '0;
            load_en_q <= 1'b0;
            dec_en_q  <= 1'b0;
            st_en_q   <= 1'b0;
            load_q    <= '0;
            dec_q     <= '0;
            st_q      <= '0;
        end else begin
            en_q      <= (en_q | thread_en_set) & ~thread_en_clr;
            stall_q   <= (stall_q & ~stall_clr) | stall_set;
            ptr_q     <= ptr_next;
            load_en_q <= sel_valid;
            load_q    <= sel_id;
            dec_en_q  <= load_en_q;
            dec_q     <= load_q;
            st_en_q   <= dec_en_q;
            st_q      <= dec_q;
        end
    end

    assign thread_load_en   = load_en_q;
    assign thread_load      = load_q;
    assign thread_decode_en = dec_en_q;
    assign thread_decode    = dec_q;
    assign thread_store_en  = st_en_q;
    assign thread_store     = st_q;
endmodule

// File: tb/tb_tawas_thread_sched.sv
// Bench for tawas_thread_sched: directed scenarios plus randomized pulses against an issue-history model.
// Honors TAWAS_SKIP_IDLE_EN in the same way as the design.
module tb_tawas_thread_sched;
    localparam int THREAD_W = 5;
    localparam int N = 1 << THREAD_W;
    localparam logic [N-1:0] START = {{(N-1){1'b0}}, 1'b1};

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        thread_en_set = '0;
    logic [N-1:0]        thread_en_clr = '0;
    logic [N-1:0]        stall_set = '0;
    logic [N-1:0]        stall_clr = '0;
    logic                thread_load_en, thread_decode_en, thread_store_en;
    logic [THREAD_W-1:0] thread_load, thread_decode, thread_store;
    logic [N-1:0]        thread_mask, thread_rdy;
    logic                idle;

    tawas_thread_sched #(.THREAD_W(THREAD_W), .START_MASK(START)) dut (
        .clk(clk), .rst(rst),
        .thread_en_set(thread_en_set), .thread_en_clr(thread_en_clr),
        .stall_set(stall_set), .stall_clr(stall_clr),
        .thread_load_en(thread_load_en), .thread_load(thread_load),
        .thread_decode_en(thread_decode_en), .thread_decode(thread_decode),
        .thread_store_en(thread_store_en), .thread_store(thread_store),
        .thread_mask(thread_mask), .thread_rdy(thread_rdy), .idle(idle)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: per-thread flags plus a history of issued slots {en,id}
    bit                  en_m[N];
    bit                  stall_m[N];
    int                  ptr_m;
    logic [THREAD_W:0]   exp_q[$];
    int                  n_checks = 0;
    int                  n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            en_m[i]    = START[i];
            stall_m[i] = 1'b0;
        end
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
    endtask

    task automatic model_step();
        bit rdy[N];
        logic [THREAD_W:0] ld, dc;
        bit found;
        int t;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) rdy[i] = en_m[i] && !stall_m[i];
        ld = exp_q[$];
        dc = exp_q[$-1];
        found = 1'b0;
        t = ptr_m;
`ifdef TAWAS_SKIP_IDLE_EN
        for (int k = 0; k < N; k++) begin
            if (!found) begin
                t = (ptr_m + k) % N;
                if (rdy[t] && !(ld[THREAD_W] && ld[THREAD_W-1:0] == t[THREAD_W-1:0])
                           && !(dc[THREAD_W] && dc[THREAD_W-1:0] == t[THREAD_W-1:0]))
                    found = 1'b1;
            end
        end
        if (found) begin
            exp_q.push_back({1'b1, t[THREAD_W-1:0]});
            ptr_m = (t + 1) % N;
        end else begin
            exp_q.push_back({1'b0, ptr_m[THREAD_W-1:0]});
            ptr_m = (ptr_m + 1) % N;
        end
`else
        exp_q.push_back({rdy[ptr_m], ptr_m[THREAD_W-1:0]});
        ptr_m = (ptr_m + 1) % N;
`endif
        if (exp_q.size() > 3) void'(exp_q.pop_front());
        for (int i = 0; i < N; i++) begin
            en_m[i]    = (en_m[i] || thread_en_set[i]) && !thread_en_clr[i];
            stall_m[i] = (stall_m[i] && !stall_clr[i]) || stall_set[i];
        end
    endtask

    task automatic compare_all();
        logic [THREAD_W:0] ld, dc, st;
        logic [N-1:0] mask_e, rdy_e;
        ld = exp_q[$];
        dc = exp_q[$-1];
        st = exp_q[$-2];
        for (int i = 0; i < N; i++) begin
            mask_e[i] = en_m[i];
            rdy_e[i]  = en_m[i] && !stall_m[i];
        end
        check_val("load_en", 64'(thread_load_en), 64'(ld[THREAD_W]));
        check_val("load", 64'(thread_load), 64'(ld[THREAD_W-1:0]));
        check_val("decode_en", 64'(thread_decode_en), 64'(dc[THREAD_W]));
        check_val("decode", 64'(thread_decode), 64'(dc[THREAD_W-1:0]));
        check_val("store_en", 64'(thread_store_en), 64'(st[THREAD_W]));
        check_val("store", 64'(thread_store), 64'(st[THREAD_W-1:0]));
        check_val("mask", 64'(thread_mask), 64'(mask_e));
        check_val("rdy", 64'(thread_rdy), 64'(rdy_e));
        check_val("idle", 64'(idle), 64'(rdy_e == '0));
    endtask

    // driver: apply one cycle of inputs, advance model at the edge, compare 1ns later
    task automatic cycle(input logic r, input logic [N-1:0] es, input logic [N-1:0] ec,
                         input logic [N-1:0] ss, input logic [N-1:0] sc);
        rst = r;
        thread_en_set = es;
        thread_en_clr = ec;
        stall_set = ss;
        stall_clr = sc;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0);
    endtask

    function automatic logic [N-1:0] sparse_vec();
        return N'($urandom & $urandom & $urandom);
    endfunction

    function automatic logic [N-1:0] bit_vec(input int b);
        logic [N-1:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        model_reset();
        repeat (3) cycle(1'b1, '0, '0, '0, '0);
        check_val("reset_load_en", 64'(thread_load_en), 64'(0));
        check_val("reset_mask", 64'(thread_mask), 64'(START));

        // reset release: slot 0 first, then the pipeline follows it
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, '0, '0, '0, '0);
`ifndef TAWAS_SKIP_IDLE_EN
            check_val("rel_load", 64'(thread_load), 64'(c));
            check_val("rel_load_en", 64'(thread_load_en), 64'(c == 0));
            if (c == 1) check_val("rel_decode_en", 64'(thread_decode_en), 64'(1));
            if (c == 2) check_val("rel_store_en", 64'(thread_store_en), 64'(1));
`endif
        end

        // enable everything, run across the 31->0 wrap
        cycle(1'b0, '1, '0, '0, '0);
        check_val("all_mask", 64'(thread_mask), 64'({N{1'b1}}));
        idle_cycles(N + 8);

        // same-cycle set/clr conflicts on thread 5
        cycle(1'b0, bit_vec(5), bit_vec(5), '0, '0);
        check_val("en_conflict", 64'(thread_mask[5]), 64'(0));
        cycle(1'b0, bit_vec(5), '0, '0, '0);
        cycle(1'b0, '0, '0, bit_vec(5), bit_vec(5));
        check_val("stall_conflict", 64'(thread_rdy[5]), 64'(0));
        idle_cycles(4);

        // reset with the pipeline full
        cycle(1'b1, '0, '0, '0, '0);
        check_val("mid_rst_dec_en", 64'(thread_decode_en), 64'(0));
        check_val("mid_rst_st_en", 64'(thread_store_en), 64'(0));
        check_val("mid_rst_mask", 64'(thread_mask), 64'(START));

        // only thread 3 enabled; stall it, run, then release
        cycle(1'b0, '0, '1, '0, '0);
        cycle(1'b0, bit_vec(3), '0, '0, '0);
        idle_cycles(N + 4);
        cycle(1'b0, '0, '0, bit_vec(3), '0);
        idle_cycles(2 * N + 3);
        cycle(1'b0, '0, '0, '0, bit_vec(3));
        idle_cycles(N + 4);

        // threads 0 and 9 only
        cycle(1'b0, bit_vec(0) | bit_vec(9), ~(bit_vec(0) | bit_vec(9)), '0, '0);
        idle_cycles(3 * N);

        // randomized pulses with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), sparse_vec(), sparse_vec(),
                  sparse_vec(), sparse_vec());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/tawas_thread_sched.md
TAWAS_THREAD_SCHED -- requirements
Module: tawas_thread_sched

Interface
REQ-001 The block SHALL have parameter THREAD_W, default 5, meaning thread-id width; legal range 1..5; N = 2**THREAD_W threads.
REQ-002 The block SHALL have parameter START_MASK, default 1, meaning the N-bit enable mask loaded at reset (bit 0 = thread 0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port thread_en_set, input, N bits: per-thread enable request, one-cycle pulse per bit.
REQ-006 The block SHALL have port thread_en_clr, input, N bits: per-thread disable request, one-cycle pulse per bit.
REQ-007 The block SHALL have port stall_set, input, N bits: marks a thread as waiting (e.g. rcn load outstanding).
REQ-008 The block SHALL have port stall_clr, input, N bits: releases a waiting thread.
REQ-009 The block SHALL have port thread_load_en, output, 1 bit: the issue slot this cycle is valid.
REQ-010 The block SHALL have port thread_load, output, THREAD_W bits: id of the thread in the fetch/load stage.
REQ-011 The block SHALL have port thread_decode_en, output, 1 bit, and port thread_decode, output, THREAD_W bits: the load stage delayed by one cycle.
REQ-012 The block SHALL have port thread_store_en, output, 1 bit, and port thread_store, output, THREAD_W bits: the load stage delayed by two cycles.
REQ-013 The block SHALL have port thread_mask, output, N bits: the current enable register.
REQ-014 The block SHALL have port thread_rdy, output, N bits: enable AND NOT stall, combinational from registered state.
REQ-015 The block SHALL have port idle, output, 1 bit: high when thread_rdy == 0.

Function
REQ-016 Enable register update SHALL be en <= (en | thread_en_set) & ~thread_en_clr; when set and clr hit the same bit in the same cycle, clr SHALL win.
REQ-017 Stall register update SHALL be stall <= (stall & ~stall_clr) | stall_set; when set and clr hit the same bit in the same cycle, set SHALL win.
REQ-018 Set/clr effects SHALL be visible in thread_mask/thread_rdy one cycle after the pulse, and SHALL affect issue selection from that cycle on.
REQ-019 The rotation pointer SHALL advance by one every cycle, modulo N: N-1 wraps to 0.
REQ-020 Fixed-rotation issue: thread_load SHALL equal the pointer, and thread_load_en SHALL equal thread_rdy[pointer]; a non-ready slot is a bubble (en=0, id still driven).
REQ-021 Decode and store stages SHALL shift every cycle, carrying id and en unconditionally; there SHALL be no backpressure.
REQ-022 A thread whose stall_set arrives while it is in decode or store SHALL complete those stages; only future issue is blocked.
REQ-023 With N=2 (THREAD_W=1) in fixed rotation, each thread issues at most every second cycle; the hazard spacing guarantee of REQ-027 SHALL NOT apply to fixed-rotation mode.
REQ-024 Latency: load to decode SHALL be 1 cycle, and load to store SHALL be 2 cycles.

Reset
REQ-025 While rst is high at a clock edge, the block SHALL set pointer=0, en=START_MASK, stall=0, all *_en outputs=0, and all thread ids=0; stage contents in flight SHALL be discarded.
REQ-026 On the first cycle after rst falls, the load slot SHALL present thread 0, with thread_load_en=START_MASK[0].

Configuration
REQ-027 With macro TAWAS_SKIP_IDLE_EN defined, the block SHALL issue each cycle the first ready thread at or after the pointer, in rotating priority order, excluding the ids currently valid in load and decode; the pointer SHALL then move to selected+1 (mod N); if no eligible thread exists, the cycle SHALL be a bubble and the pointer SHALL advance by one. This guarantees a minimum 3-cycle spacing between issues of one thread.
REQ-028 Without TAWAS_SKIP_IDLE_EN, the block SHALL use strict fixed rotation per REQ-019/020, and the skip logic SHALL be absent.

Verification
REQ-029 Reset release, default params -> cycles 0..3 show thread_load 0,1,2,3 with thread_load_en 1,0,0,0; thread_decode=0 and thread_decode_en=1 at cycle 1; thread_store=0 and thread_store_en=1 at cycle 2.
REQ-030 thread_en_set=0xFFFFFFFF pulse -> thread_mask=0xFFFFFFFF next cycle; thread_load_en=1 every cycle; thread_load wraps 31->0.
REQ-031 Same-cycle thread_en_set[5]=1 and thread_en_clr[5]=1 -> thread_mask[5]=0; same-cycle stall_set[5]=1 and stall_clr[5]=1 -> stall held (thread_rdy[5]=0).
REQ-032 Thread 3 enabled, stall_set[3] pulsed -> no issue of 3 until stall_clr[3]; the first slot with pointer=3 after the clear issues it.
REQ-033 SKIP_IDLE_EN, only threads 0 and 9 ready -> issue pattern 0,9,bubble,0,9,bubble...; no id repeats within 3 cycles.
REQ-034 rst asserted while threads are in decode/store -> all *_en outputs 0 the next cycle; en=START_MASK.
